mul_sequencer: RTL and testbench
================================

Name: mul_sequencer

Overview:
- Iterative radix-2 shift-add multiplier controller for the M-extension ops that the control unit decodes: mul, mulh and mulhu (aluop 0101/0110/0111).
- Sits beside the single-cycle ALU in the RIU datapath.
- Holds the pipeline via busy while the operation runs. Delivers the 32-bit result with a one-cycle done pulse for regsel writeback.

Parameters:
- WIDTH, 32, operand and result width. Iteration count equals WIDTH, counter width is clog2(WIDTH)+1.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  request to begin; sampled only in IDLE or DONE
- aluop  input  4  op code: 0101 mul, 0110 mulh, 0111 mulhu; any other code means start is ignored
- op_a  input  WIDTH  multiplicand (rs1)
- op_b  input  WIDTH  multiplier (rs2)
- busy  output  1  high in RUN and SIGN states
- done  output  1  one-cycle pulse in the DONE state
- result  output  WIDTH  registered result; held until the next accepted start

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, busy=0, done=0, result=0, counter=0, internal accumulators=0. Reset takes effect from any state, including mid-RUN; the partial product is discarded.
- States: IDLE, RUN, SIGN, DONE.
- Accept condition: start=1 AND aluop is one of {0101,0110,0111} AND state is IDLE or DONE. On the accepting edge:
  - latch the op
  - load the multiplicand register (2*WIDTH wide) with |op_a| if mulh, else op_a zero-extended
  - load the multiplier register with |op_b| if mulh, else op_b
  - negate flag = op_a[MSB] XOR op_b[MSB] if mulh, else 0
  - product=0, counter=0, go to RUN
- Magnitude of the most negative value (0x80000000) is 0x80000000 read as unsigned; no overflow.
- RUN, each cycle:
  - if multiplier[0]=1, product += multiplicand
  - multiplicand <<= 1, multiplier >>= 1 (logical), counter++
  - after WIDTH RUN cycles go to SIGN
  - no early termination: latency is fixed regardless of operand values
- SIGN, one cycle: if negate, product = two's complement of product (2*WIDTH bits). Then go to DONE.
- DONE, one cycle:
  - done=1
  - result = product[WIDTH-1:0] for mul, product[2*WIDTH-1:WIDTH] for mulh/mulhu; result is registered on entry to DONE, so it is valid in the same cycle done=1
  - next state is IDLE, or RUN if a valid start is accepted this cycle (back-to-back)
- Latency: start accepted at edge k gives RUN during cycles k+1..k+WIDTH, SIGN at k+WIDTH+1, done=1 at k+WIDTH+2 (34 cycles for WIDTH=32).
- start while busy=1: ignored. No queueing, state and registers unaffected.
- Operand changes after acceptance: ignored (latched).
- mul sign handling: low product bits are signedness-independent; unsigned path, no negation.
- result persists across IDLE; it changes only on entry to DONE or on reset.

Test Plan:
- Reset, then mul: op_a=7, op_b=6, aluop=0101, start for 1 cycle -> busy=1 for 33 cycles, done=1 exactly 34 cycles after the accepting edge, result=0x0000002A, done low the next cycle.
- mulh: op_a=0xFFFFFFFD (-3), op_b=5 -> result=0xFFFFFFFF. Also mulh 0x80000000 x 0x80000000 -> result=0x40000000. Also mul 0xFFFFFFFF x 0xFFFFFFFF -> result=0x00000001.
- mulhu: 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE. Then, back-to-back, start held in the DONE cycle with mulhu 0x00010000 x 0x00010000 -> second done 34 cycles later with result=0x00000001 and no IDLE cycle in between.
- Protocol: start pulsed at cycle 10 of a RUN with different operands, changing op_a mid-RUN -> no effect, original result delivered. start with aluop=0011 in IDLE -> stays IDLE, busy=0, no done ever.
- Reset mid-operation: rst_n=0 for 1 cycle at RUN cycle 15 -> next cycle state IDLE, busy=0, done=0, result=0. A subsequent mul 3x4 -> result=12 with full 34-cycle latency.

Source files
------------

// File: rtl/mul_sequencer.sv
// Iterative radix-2 shift-add multiplier for mul/mulh/mulhu.
// Holds the pipeline via busy and returns the result with a one-cycle done pulse.
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [3:0] OP_MUL   = 4'b0101;
  localparam logic [3:0] OP_MULH  = 4'b0110;
  localparam logic [3:0] OP_MULHU = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    SIGN = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t               state_r;
  logic                 is_mul_r;
  logic                 negate_r;
  logic [2*WIDTH-1:0]   multiplicand_r;
  logic [WIDTH-1:0]     multiplier_r;
  logic [2*WIDTH-1:0]   product_r;
  logic [CW-1:0]        counter_r;
  logic                 busy_r;
  logic                 done_r;
  logic [WIDTH-1:0]     result_r;

  logic                 valid_op_s;
  logic                 is_mulh_s;
  logic                 accept_s;
  logic [2*WIDTH-1:0]   product_signed_s;

  // Unsigned magnitude; the most negative value maps to itself read as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      magnitude = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      magnitude = v;
    end
  endfunction

  // Decode the request and form the sign-corrected product.
  always_comb begin
    valid_op_s = 1'b0;
    case (aluop)
      OP_MUL, OP_MULH, OP_MULHU: valid_op_s = 1'b1;
      default:                   valid_op_s = 1'b0;
    endcase
    is_mulh_s = (aluop == OP_MULH);
    accept_s  = start && valid_op_s && ((state_r == IDLE) || (state_r == DONE));
    if (negate_r) begin
      product_signed_s = ~product_r + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else begin
      product_signed_s = product_r;
    end
  end

  // Sequencer state, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      is_mul_r       <= 1'b0;
      negate_r       <= 1'b0;
      multiplicand_r <= {(2*WIDTH){1'b0}};
      multiplier_r   <= {WIDTH{1'b0}};
      product_r      <= {(2*WIDTH){1'b0}};
      counter_r      <= {CW{1'b0}};
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      result_r       <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      state_r        <= RUN;
      is_mul_r       <= (aluop == OP_MUL);
      negate_r       <= is_mulh_s ? (op_a[WIDTH-1] ^ op_b[WIDTH-1]) : 1'b0;
      multiplicand_r <= {{WIDTH{1'b0}}, (is_mulh_s ? magnitude(op_a) : op_a)};
      multiplier_r   <= is_mulh_s ? magnitude(op_b) : op_b;
      product_r      <= {(2*WIDTH){1'b0}};
      counter_r      <= {CW{1'b0}};
      busy_r         <= 1'b1;
      done_r         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
        RUN: begin
          if (multiplier_r[0]) begin
            product_r <= product_r + multiplicand_r;
          end
          multiplicand_r <= multiplicand_r << 1;
          multiplier_r   <= multiplier_r >> 1;
          counter_r      <= counter_r + {{(CW-1){1'b0}}, 1'b1};
          if (counter_r == CW'(WIDTH - 1)) begin
            state_r <= SIGN;
          end
        end
        SIGN: begin
          // Result is captured here so it is valid alongside the done pulse.
          product_r <= product_signed_s;
          result_r  <= is_mul_r ? product_signed_s[WIDTH-1:0]
                                : product_signed_s[2*WIDTH-1:WIDTH];
          busy_r    <= 1'b0;
          done_r    <= 1'b1;
          state_r   <= DONE;
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed vector table, multi-cycle
// corner sequences and randomized ops against an arithmetic reference.
module tb_mul_sequencer;

  localparam logic [3:0] OP_MUL   = 4'b0101;
  localparam logic [3:0] OP_MULH  = 4'b0110;
  localparam logic [3:0] OP_MULHU = 4'b0111;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  aluop;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  mul_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .aluop (aluop),
    .op_a  (op_a),
    .op_b  (op_b),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: full-precision product from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_mul(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    case (op)
      OP_MULH: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
        return p[63:32];
      end
      OP_MULHU: begin
        p = {32'd0, a} * {32'd0, b};
        return p[63:32];
      end
      default: begin
        p = {32'd0, a} * {32'd0, b};
        return p[31:0];
      end
    endcase
  endfunction

  // Present a request before the next rising edge; that edge accepts it.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    aluop = op;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
  endtask

  // Cycle 1 is the cycle after the accepting edge: busy is expected in
  // cycles 1..33 and done in cycle 34 only.
  task automatic watch(input logic [31:0] exp, input string name, input bit chain,
                       input logic [3:0] nop, input logic [31:0] na, input logic [31:0] nb,
                       input bit disturb);
    int done_cyc = 0;
    int busy_cnt = 0;
    bit stop     = 1'b0;
    for (int cyc = 1; cyc <= 40 && !stop; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (disturb) begin
        if (cyc == 10) begin
          start = 1'b1;
          aluop = OP_MULHU;
          op_a  = $urandom;
          op_b  = $urandom;
        end
        if (cyc == 11) start = 1'b0;
        if (cyc == 12) op_a = $urandom;
      end
      if (busy) busy_cnt++;
      if (done_cyc != 0) begin
        check({name, " done_low_after"}, {31'd0, done}, 32'd0);
        stop = 1'b1;
      end else if (done) begin
        done_cyc = cyc;
        check({name, " result"}, result, exp);
        check({name, " done_cycle"}, done_cyc, 32'd34);
        check({name, " busy_cycles"}, busy_cnt, 32'd33);
        if (chain) begin
          aluop = nop;
          op_a  = na;
          op_b  = nb;
          start = 1'b1;
          stop  = 1'b1;
        end
      end
    end
    if (done_cyc == 0) check({name, " done_seen"}, 32'd0, 32'd1);
  endtask

  vec_t        vecs[5];
  logic [3:0]  rop;
  logic [31:0] ra;
  logic [31:0] rb;
  logic [31:0] saved;
  int          busy_seen;
  int          done_seen;

  initial begin
    vecs[0] = '{OP_MUL,   32'd7,          32'd6,          32'h0000002A, "mul_7x6"};
    vecs[1] = '{OP_MULH,  32'hFFFFFFFD,   32'd5,          32'hFFFFFFFF, "mulh_m3x5"};
    vecs[2] = '{OP_MULH,  32'h80000000,   32'h80000000,   32'h40000000, "mulh_min_sq"};
    vecs[3] = '{OP_MUL,   32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001, "mul_ff_sq"};
    vecs[4] = '{OP_MULH,  32'h7FFFFFFF,   32'h80000000,   32'hC0000000, "mulh_max_min"};

    rst_n = 1'b0;
    start = 1'b0;
    aluop = 4'd0;
    op_a  = 32'd0;
    op_b  = 32'd0;
    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      watch(vecs[i].exp, vecs[i].name, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    end

    // Back-to-back: second request held during the DONE cycle.
    issue(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    watch(32'hFFFFFFFE, "mulhu_ff_sq", 1'b1, OP_MULHU, 32'h00010000, 32'h00010000, 1'b0);
    watch(32'h00000001, "mulhu_b2b", 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);

    // Start and operand changes while busy are ignored.
    issue(OP_MUL, 32'h00001234, 32'h00000010);
    watch(32'h00012340, "mul_disturbed", 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);

    // Unsupported opcode never starts an operation.
    saved = result;
    busy_seen = 0;
    done_seen = 0;
    issue(4'b0011, 32'd9, 32'd9);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (busy) busy_seen++;
      if (done) done_seen++;
    end
    check("bad_op busy_seen", busy_seen, 32'd0);
    check("bad_op done_seen", done_seen, 32'd0);
    check("bad_op result_held", result, saved);

    // Reset in RUN cycle 15 discards the operation.
    issue(OP_MULHU, 32'hDEADBEEF, 32'h12345678);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    check("midrst result", result, 32'd0);
    rst_n = 1'b1;
    issue(OP_MUL, 32'd3, 32'd4);
    watch(32'd12, "mul_3x4_after_rst", 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(2, 0))
        0:       rop = OP_MUL;
        1:       rop = OP_MULH;
        default: rop = OP_MULHU;
      endcase
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) ra = 32'h80000000;
      if (i % 4 == 2) rb = 32'hFFFFFFFF;
      issue(rop, ra, rb);
      watch(ref_mul(rop, ra, rb), $sformatf("rand%0d_op%0h", i, rop), 1'b0,
            4'd0, 32'd0, 32'd0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
